// File: rtl/psum_collector.sv
// psum_collector: per-column FIFOs that de-skew systolic column partial sums into aligned output vectors.
module psum_collector #(
  parameter int COLS   = 4,
  parameter int PSUM_W = 24,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COLS-1:0]          col_valid,
  input  logic [COLS*PSUM_W-1:0]   col_psum,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*PSUM_W-1:0]   out_data,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         vec_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HIGH = (AW+1)'(DEPTH - 1);

  logic [PSUM_W-1:0]        mem_q    [COLS][DEPTH];
  logic [AW-1:0]            wr_ptr_q [COLS];
  logic [AW-1:0]            wr_ptr_d [COLS];
  logic [AW-1:0]            rd_ptr_q [COLS];
  logic [AW-1:0]            rd_ptr_d [COLS];
  logic [AW:0]              cnt_q    [COLS];
  logic [AW:0]              cnt_d    [COLS];
  logic [COLS-1:0]          wr, drop, nonempty, high;
  logic                     pop;
  logic [COLS*PSUM_W-1:0]   head, out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     almost_full_q, almost_full_d;
  logic                     overflow_q, overflow_d;
  logic [CNT_W-1:0]         vec_cnt_q, vec_cnt_d;

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      nonempty[c] = cnt_q[c] != '0;
      head[c*PSUM_W +: PSUM_W] = mem_q[c][rd_ptr_q[c]];
    end
  end

  // All lanes pop together so a vector is never split across output beats.
  assign pop = !flush && (!out_valid_q || out_ready) && (&nonempty);

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      wr[c]       = !flush && col_valid[c] && (cnt_q[c] != FULL || pop);
      drop[c]     = !flush && col_valid[c] && cnt_q[c] == FULL && !pop;
      wr_ptr_d[c] = flush ? '0 : wr_ptr_q[c] + AW'(wr[c]);
      rd_ptr_d[c] = flush ? '0 : rd_ptr_q[c] + AW'(pop);
      cnt_d[c]    = flush ? '0 : cnt_q[c] + (AW+1)'(wr[c]) - (AW+1)'(pop);
      high[c]     = cnt_d[c] >= HIGH;
    end
  end

  assign out_valid_d   = !flush && (pop || (out_valid_q && !out_ready));
  assign out_data_d    = pop ? head : out_data_q;
  assign overflow_d    = !flush && (overflow_q || (|drop));
  assign almost_full_d = |high;
  assign vec_cnt_d     = vec_cnt_q + CNT_W'(out_valid_q && out_ready && !flush);

  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++)
      if (wr[c]) mem_q[c][wr_ptr_q[c]] <= col_psum[c*PSUM_W +: PSUM_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      vec_cnt_q     <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      vec_cnt_q     <= vec_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign vec_cnt     = vec_cnt_q;
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: table-driven and hand-sequenced checks of psum_collector with a vector scoreboard.
module tb_psum_collector;
  localparam int COLS = 4, PW = 24, DEPTH = 4, CW = 16, DW = COLS * PW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [COLS-1:0] col_valid = '0;
  logic [DW-1:0]   col_psum = '0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid, almost_full, overflow;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   vec_cnt;

  psum_collector #(.COLS(COLS), .PSUM_W(PW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .col_valid(col_valid), .col_psum(col_psum), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .almost_full(almost_full), .overflow(overflow), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q [$];

  typedef struct {
    int         t;
    logic [3:0] mask;
    logic       ready;
    logic       ev;
    logic       eaf;
    int         vd;
  } row_t;
  row_t tbl [19];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] vec(input int a, input int s);
    logic [DW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*PW +: PW] = PW'(a + s * c);
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // A transfer happens on the coming edge; compare it against the oldest expected vector.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_vector: got %0h expected none", out_data);
      end else chk("vector", out_data, exp_q.pop_front());
    end
  end

  task automatic run_tbl(input int lo, input int hi, input int vbase);
    for (int i = lo; i <= hi; i++) begin
      col_valid = tbl[i].mask;
      out_ready = tbl[i].ready;
      for (int c = 0; c < COLS; c++)
        col_psum[c*PW +: PW] = tbl[i].mask[c] ? PW'(100 * (tbl[i].t - c) + c) : 24'hBAD;
      if (tbl[i].mask[0]) exp_q.push_back(vec(100 * tbl[i].t, 1));
      cyc();
      chk("tbl_out_valid", out_valid, tbl[i].ev);
      chk("tbl_almost_full", almost_full, tbl[i].eaf);
      chk("tbl_vec_cnt", vec_cnt, DW'(vbase + tbl[i].vd));
      chk("tbl_overflow", overflow, 0);
      if (!tbl[i].ready && tbl[i].ev) chk("tbl_hold_data", out_data, vec(0, 1));
    end
    col_valid = '0;
  endtask

  initial begin
    tbl[0]  = '{0, 4'b0001, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{1, 4'b0011, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{2, 4'b0111, 1'b1, 1'b0, 1'b1, 0};
    tbl[3]  = '{3, 4'b1111, 1'b1, 1'b0, 1'b1, 0};
    tbl[4]  = '{4, 4'b1110, 1'b1, 1'b1, 1'b1, 0};
    tbl[5]  = '{5, 4'b1100, 1'b1, 1'b1, 1'b0, 1};
    tbl[6]  = '{6, 4'b1000, 1'b1, 1'b1, 1'b0, 2};
    tbl[7]  = '{7, 4'b0000, 1'b1, 1'b1, 1'b0, 3};
    tbl[8]  = '{8, 4'b0000, 1'b1, 1'b0, 1'b0, 4};
    tbl[9]  = '{0, 4'b0001, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{1, 4'b0011, 1'b0, 1'b0, 1'b0, 0};
    tbl[11] = '{2, 4'b0111, 1'b0, 1'b0, 1'b1, 0};
    tbl[12] = '{3, 4'b1111, 1'b0, 1'b0, 1'b1, 0};
    tbl[13] = '{4, 4'b1110, 1'b0, 1'b1, 1'b1, 0};
    tbl[14] = '{5, 4'b1100, 1'b0, 1'b1, 1'b1, 0};
    tbl[15] = '{6, 4'b1000, 1'b1, 1'b1, 1'b0, 1};
    tbl[16] = '{7, 4'b0000, 1'b1, 1'b1, 1'b0, 2};
    tbl[17] = '{8, 4'b0000, 1'b1, 1'b1, 1'b0, 3};
    tbl[18] = '{9, 4'b0000, 1'b1, 1'b0, 1'b0, 4};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    rst_n = 1'b1;
    cyc();

    run_tbl(0, 8, 0);
    chk("s1_queue_empty", exp_q.size(), 0);
    run_tbl(9, 18, 4);
    chk("s2_queue_empty", exp_q.size(), 0);

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      col_valid = 4'b0001;
      col_psum = '0;
      col_psum[0 +: PW] = PW'(500 + i);
      if (i < 4) exp_q.push_back(vec(500 + i, 100));
      cyc();
      if (i == 2) chk("ovf_almost_full", almost_full, 1);
      if (i == 3) chk("ovf_not_yet", overflow, 0);
      if (i == 4) chk("ovf_set", overflow, 1);
    end
    for (int k = 0; k < 4; k++) begin
      col_valid = 4'b1110;
      for (int c = 1; c < COLS; c++) col_psum[c*PW +: PW] = PW'(500 + 100 * c + k);
      cyc();
    end
    col_valid = '0;
    chk("ovf_first_valid", out_valid, 1);
    chk("ovf_first_data", out_data, vec(500, 100));
    out_ready = 1'b1;
    repeat (6) cyc();
    chk("ovf_vec_cnt", vec_cnt, 12);
    chk("ovf_queue_empty", exp_q.size(), 0);
    chk("ovf_drained", out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      col_valid = 4'b1111;
      col_psum = vec(3000 + k, 100);
      exp_q.push_back(vec(3000 + k, 100));
      cyc();
    end
    chk("fl_pre_valid", out_valid, 1);
    chk("fl_pre_af", almost_full, 1);
    flush = 1'b1;
    out_ready = 1'b1;
    col_psum = vec(3900, 100);
    cyc();
    flush = 1'b0;
    col_valid = '0;
    exp_q.delete();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_almost_full", almost_full, 0);
    chk("fl_overflow", overflow, 0);
    chk("fl_vec_cnt", vec_cnt, 12);
    chk("fl_data_kept", out_data, vec(3000, 100));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("fl_idle_valid", out_valid, 0);
    end
    run_tbl(0, 8, 12);
    chk("fl_queue_empty", exp_q.size(), 0);

    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      col_valid = (k < 2) ? 4'b1111 : 4'b0001;
      col_psum = vec(1000 + k, 100);
      exp_q.push_back(vec(1000 + k, 100));
      cyc();
    end
    out_ready = 1'b1;
    col_valid = 4'b0001;
    col_psum = vec(1005, 100);
    exp_q.push_back(vec(1005, 100));
    cyc();
    chk("fp_overflow", overflow, 0);
    chk("fp_almost_full", almost_full, 1);
    chk("fp_out_valid", out_valid, 1);
    chk("fp_out_data", out_data, vec(1001, 100));
    for (int k = 2; k < 6; k++) begin
      col_valid = 4'b1110;
      col_psum = vec(1000 + k, 100);
      cyc();
    end
    col_valid = '0;
    repeat (6) cyc();
    chk("fp_queue_empty", exp_q.size(), 0);
    chk("fp_vec_cnt", vec_cnt, 22);
    chk("fp_overflow_end", overflow, 0);
    chk("fp_drained", out_valid, 0);

    run_tbl(0, 4, 22);
    #2;
    rst_n = 1'b0;
    col_valid = '0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_almost_full", almost_full, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_vec_cnt", vec_cnt, 0);
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("arst_no_stale", out_valid, 0);
    end
    run_tbl(0, 8, 0);
    chk("arst_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
